// File: rtl/apb_completer_regbank_pkg.sv
// Shared types and constants for the APB completer register bank.
// Latency: n/a (types only).
// Backpressure: n/a.
package AXI_to_APB;

    // Completer transfer state: waiting for SETUP, or inside the ACCESS phase.
    typedef enum logic {
        APB_IDLE   = 1'b0,
        APB_ACCESS = 1'b1
    } apb_state_t;

    localparam logic       APB_OKAY     = 1'b0;
    localparam logic       APB_SLVERR   = 1'b1;
    localparam logic [2:0] APB_NO_SLAVE = 3'd0;

endpackage

// File: rtl/apb_completer_regbank_if.sv
// APB bus bundle between the bridge (master) and one completer (slave).
// Latency: n/a (wires only).
// Backpressure: completer stretches ACCESS by holding pready low.
// Signals: psel (encoded select), penable, pwrite, paddr, pwdata toward the completer;
//          prdata, pready, pslverr back toward the master.
interface apb_completer_regbank_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [2:0]            psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_completer_regbank_reg_bank.sv
// Register storage: reg0 = constant ID, reg1 = saturating error counter, reg2.. = read/write.
// Latency: writes visible on o_reg_q one cycle after i_wr_en; read port is combinational.
// Backpressure: none, a write is taken whenever i_wr_en is high.
// Ports: pclk/preset; i_wr_en/i_wr_idx/i_wr_dat write port; i_err_inc counter bump;
//        i_rd_idx -> o_rd_dat read port; o_reg_q flat view of every word.
module apb_reg_bank #(
    parameter int                   NUM_REGS   = 16,
    parameter int                   DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE  = 32'hA9B0_0001,
    localparam int                  IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic                           i_wr_en,
    input  logic [IDX_W-1:0]               i_wr_idx,
    input  logic [DATA_WIDTH-1:0]          i_wr_dat,
    input  logic                           i_err_inc,
    input  logic [IDX_W-1:0]               i_rd_idx,
    output logic [DATA_WIDTH-1:0]          o_rd_dat,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_q
);
    logic [DATA_WIDTH-1:0] w_words [NUM_REGS];
    logic [7:0]            r_err_cnt;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_err_cnt <= 8'h00;
        end else if (i_err_inc && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    for (genvar n = 0; n < NUM_REGS; n++) begin : g_word
        if (n == 0) begin : g_id
            assign w_words[n] = ID_VALUE;
        end else if (n == 1) begin : g_err
            assign w_words[n] = {{(DATA_WIDTH-8){1'b0}}, r_err_cnt};
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] r_q;
            always_ff @(posedge pclk or posedge preset) begin
                if (preset) begin
                    r_q <= '0;
                end else if (i_wr_en && (i_wr_idx == IDX_W'(n))) begin
                    r_q <= i_wr_dat;
                end
            end
            assign w_words[n] = r_q;
        end
        assign o_reg_q[n*DATA_WIDTH +: DATA_WIDTH] = w_words[n];
    end

    assign o_rd_dat = w_words[i_rd_idx];
endmodule

// File: rtl/apb_completer_regbank.sv
// APB completer: decodes encoded psel, serves a local register bank, adds wait states, flags errors.
// Latency: pready in ACCESS cycle WAIT_STATES+1 after SETUP, so 2+WAIT_STATES cycles per transfer.
// Backpressure: holds pready low for WAIT_STATES cycles; a dropped psel/penable aborts the transfer.
// Ports: pclk/preset; apb (slave modport) bus; reg_q flat register contents, reg n at [n*DW +: DW].
module apb_completer_regbank
    import AXI_to_APB::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [2:0]            SLAVE_ID    = 3'd1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                           pclk,
    input  logic                           preset,
    apb_completer_regbank_if.slave         apb,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);
    localparam int                    IDX_W     = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(NUM_REGS * 4);

    apb_state_t            r_state;
    apb_state_t            w_state_nxt;
    logic                  r_pwrite;
    logic                  r_err;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [3:0]            r_wait_cnt;

    logic                  w_sel;
    logic                  w_setup;
    logic                  w_ready;
    logic                  w_done;
    logic                  w_wait_inc;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_dec_err;
    logic [DATA_WIDTH-1:0] w_rd_dat;

    // psel 0 means "nobody", so it can never match even if SLAVE_ID were misconfigured to 0.
    assign w_sel = (apb.psel != APB_NO_SLAVE) && (apb.psel == SLAVE_ID);

    // Offset wraps when paddr < BASE_ADDR; that case is caught by the explicit compare below.
    assign w_offset  = apb.paddr - BASE_ADDR;
    assign w_idx     = w_offset[IDX_W+1:2];
    assign w_dec_err = (apb.paddr < BASE_ADDR)
                    || (w_offset >= WIN_BYTES)
                    || (apb.paddr[1:0] != 2'b00)
                    || (apb.pwrite && (w_idx < IDX_W'(2)));

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= APB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_setup     = 1'b0;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        w_wait_inc  = 1'b0;
        case (r_state)
            APB_IDLE: begin
                if (w_sel && !apb.penable) begin
                    w_setup     = 1'b1;
                    w_state_nxt = APB_ACCESS;
                end
            end
            APB_ACCESS: begin
                w_ready = (r_wait_cnt == 4'(WAIT_STATES));
                if (w_sel && apb.penable) begin
                    if (w_ready) begin
                        w_done      = 1'b1;
                        w_state_nxt = APB_IDLE;
                    end else begin
                        w_wait_inc  = 1'b1;
                    end
                end else begin
                    // Master abandoned the transfer: drop it without side effects.
                    w_state_nxt = APB_IDLE;
                end
            end
            default: w_state_nxt = APB_IDLE;
        endcase
    end

    // Everything the ACCESS phase needs is captured at SETUP, so later bus changes are ignored.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_pwrite   <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_rd_data  <= '0;
            r_wait_cnt <= 4'd0;
        end else if (w_setup) begin
            r_pwrite   <= apb.pwrite;
            r_err      <= w_dec_err;
            r_idx      <= w_idx;
            r_wdata    <= apb.pwdata;
            r_rd_data  <= w_dec_err ? '0 : w_rd_dat;
            r_wait_cnt <= 4'd0;
        end else if (w_wait_inc) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    assign apb.pready  = w_ready;
    assign apb.pslverr = (w_ready && r_err) ? APB_SLVERR : APB_OKAY;
    assign apb.prdata  = (r_pwrite || r_err) ? '0 : r_rd_data;

    apb_reg_bank #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .ID_VALUE   (ID_VALUE)
    ) u_reg_bank (
        .pclk      (pclk),
        .preset    (preset),
        .i_wr_en   (w_done && r_pwrite && !r_err),
        .i_wr_idx  (r_idx),
        .i_wr_dat  (r_wdata),
        .i_err_inc (w_done && r_err),
        .i_rd_idx  (w_idx),
        .o_rd_dat  (w_rd_dat),
        .o_reg_q   (reg_q)
    );
endmodule

// File: tb/tb_apb_completer_regbank.sv
// Bench for apb_completer_regbank: three completers on one shared APB bus.
// A: id 1, no wait states; B: id 2, 3 wait states; C: id 3, base 0x1000, 5 wait states.
// Stimulus is a vector table plus hand sequences for select, abort, saturation and reset cases.
module tb_apb_completer_regbank;
    logic        pclk;
    logic        preset;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [511:0] reg_q_a, reg_q_b, reg_q_c;

    int checks   = 0;
    int failures = 0;

    apb_completer_regbank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb_a ();
    apb_completer_regbank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb_b ();
    apb_completer_regbank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb_c ();

    assign apb_a.psel = psel;  assign apb_a.penable = penable;  assign apb_a.pwrite = pwrite;
    assign apb_a.paddr = paddr; assign apb_a.pwdata = pwdata;
    assign apb_b.psel = psel;  assign apb_b.penable = penable;  assign apb_b.pwrite = pwrite;
    assign apb_b.paddr = paddr; assign apb_b.pwdata = pwdata;
    assign apb_c.psel = psel;  assign apb_c.penable = penable;  assign apb_c.pwrite = pwrite;
    assign apb_c.paddr = paddr; assign apb_c.pwdata = pwdata;

    apb_completer_regbank #(.SLAVE_ID(3'd1), .WAIT_STATES(0)) u_a (
        .pclk(pclk), .preset(preset), .apb(apb_a), .reg_q(reg_q_a));
    apb_completer_regbank #(.SLAVE_ID(3'd2), .WAIT_STATES(3)) u_b (
        .pclk(pclk), .preset(preset), .apb(apb_b), .reg_q(reg_q_b));
    apb_completer_regbank #(.SLAVE_ID(3'd3), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(5),
                            .ID_VALUE(32'hA9B0_0003)) u_c (
        .pclk(pclk), .preset(preset), .apb(apb_c), .reg_q(reg_q_c));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic sel_rdy(input logic [2:0] s);
        case (s)
            3'd1:    return apb_a.pready;
            3'd2:    return apb_b.pready;
            3'd3:    return apb_c.pready;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic sel_err(input logic [2:0] s);
        case (s)
            3'd1:    return apb_a.pslverr;
            3'd2:    return apb_b.pslverr;
            3'd3:    return apb_c.pslverr;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] sel_rdata(input logic [2:0] s);
        case (s)
            3'd1:    return apb_a.prdata;
            3'd2:    return apb_b.prdata;
            3'd3:    return apb_c.prdata;
            default: return 32'h0;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the completion edge, bus still driven,
    // so consecutive calls are back-to-back. lat = ACCESS cycles up to and including pready (-1 on timeout).
    task automatic xfer(input logic [2:0] s, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
        logic done;
        psel = s; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        // The completer must use the SETUP-time address/data, so scramble them now.
        paddr = ~a; pwdata = ~d;
        lat = 0; rd = 32'h0; er = 1'b0; done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge pclk);
            lat++;
            if (sel_rdy(s)) begin
                rd = sel_rdata(s);
                er = sel_err(s);
                done = 1'b1;
            end else begin
                @(posedge pclk); #1;
            end
        end
        if (!done) begin
            lat = -1;
            psel = 3'd0; penable = 1'b0;
        end
        @(posedge pclk); #1;
    endtask

    task automatic bus_idle();
        psel = 3'd0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          hits;

        vecs[0]  = '{3'd1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1};
        vecs[1]  = '{3'd1, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1};
        vecs[2]  = '{3'd1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA9B0_0001, 1'b0, 1};
        vecs[3]  = '{3'd1, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 1'b1, 1};
        vecs[4]  = '{3'd1, 1'b1, 32'h0000_0041, 32'h2222_2222, 32'h0000_0000, 1'b1, 1};
        vecs[5]  = '{3'd1, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
        vecs[6]  = '{3'd1, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0000_0003, 1'b0, 1};
        vecs[7]  = '{3'd1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA9B0_0001, 1'b0, 1};
        vecs[8]  = '{3'd1, 1'b1, 32'h0000_003C, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1};
        vecs[9]  = '{3'd1, 1'b0, 32'h0000_003C, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 1};
        vecs[10] = '{3'd1, 1'b0, 32'h0000_0006, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
        vecs[11] = '{3'd2, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA9B0_0001, 1'b0, 4};
        vecs[12] = '{3'd2, 1'b1, 32'h0000_0010, 32'h5A5A_0000, 32'h0000_0000, 1'b0, 4};
        vecs[13] = '{3'd2, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h5A5A_0000, 1'b0, 4};
        vecs[14] = '{3'd3, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 32'h0000_0000, 1'b1, 6};
        vecs[15] = '{3'd3, 1'b0, 32'h0000_1000, 32'h0000_0000, 32'hA9B0_0003, 1'b0, 6};
        vecs[16] = '{3'd3, 1'b0, 32'h0000_1040, 32'h0000_0000, 32'h0000_0000, 1'b1, 6};

        // Reset state
        preset = 1'b1;
        bus_idle();
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_pready_a", {31'h0, apb_a.pready}, 32'h0);
        chk("rst_pready_b", {31'h0, apb_b.pready}, 32'h0);
        chk("rst_pslverr_a", {31'h0, apb_a.pslverr}, 32'h0);
        chk("rst_prdata_a", apb_a.prdata, 32'h0);
        chk("rst_reg0_a", reg_q_a[31:0], 32'hA9B0_0001);
        chk("rst_reg1_a", reg_q_a[63:32], 32'h0);
        chk("rst_reg2_a", reg_q_a[95:64], 32'h0);
        preset = 1'b0;
        @(posedge pclk); #1;

        // Vector table, transfers issued back-to-back
        for (int i = 0; i < 17; i++) begin
            xfer(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_pslverr", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
            chk($sformatf("v%0d_prdata", i), rd, vecs[i].exp_rd);
        end
        bus_idle();
        @(posedge pclk); #1;
        chk("a_reg0_unchanged", reg_q_a[31:0], 32'hA9B0_0001);
        chk("a_reg1_errcnt", reg_q_a[63:32], 32'h0000_0004);
        chk("a_reg2_q", reg_q_a[95:64], 32'hDEAD_BEEF);
        chk("a_reg15_q", reg_q_a[511:480], 32'hCAFE_F00D);
        chk("b_reg4_q", reg_q_b[159:128], 32'h5A5A_0000);

        // psel=2 must not select A (B, id 2, takes the write instead)
        psel = 3'd2; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h0BAD_0BAD;
        @(posedge pclk); #1;
        penable = 1'b1;
        hits = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge pclk);
            if (apb_a.pready) hits++;
            @(posedge pclk); #1;
        end
        bus_idle();
        @(posedge pclk); #1;
        chk("psel2_a_pready_count", hits, 0);
        chk("psel2_a_reg2", reg_q_a[95:64], 32'hDEAD_BEEF);
        chk("psel2_b_reg2", reg_q_b[95:64], 32'h0BAD_0BAD);

        // psel=0 selects nobody
        psel = 3'd0; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h7777_7777;
        @(posedge pclk); #1;
        penable = 1'b1;
        hits = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge pclk);
            if (apb_a.pready || apb_b.pready || apb_c.pready) hits++;
            @(posedge pclk); #1;
        end
        bus_idle();
        @(posedge pclk); #1;
        chk("psel0_pready_count", hits, 0);
        chk("psel0_a_reg2", reg_q_a[95:64], 32'hDEAD_BEEF);
        chk("psel0_b_reg2", reg_q_b[95:64], 32'h0BAD_0BAD);
        chk("psel0_c_reg2", reg_q_c[95:64], 32'h0);

        // Error counter saturation: A already has 4 errors, add 260 more
        hits = 0;
        for (int k = 0; k < 260; k++) begin
            xfer(3'd1, 1'b1, 32'h0, 32'hFFFF_FFFF, rd, er, lat);
            if (!er || lat != 1) hits++;
        end
        chk("sat_bad_err_responses", hits, 0);
        xfer(3'd1, 1'b0, 32'h4, 32'h0, rd, er, lat);
        chk("sat_reg1_read", rd, 32'h0000_00FF);
        chk("sat_reg0", reg_q_a[31:0], 32'hA9B0_0001);
        bus_idle();
        @(posedge pclk); #1;

        // Drop penable mid-wait on C, then retry the same write
        psel = 3'd3; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_100C; pwdata = 32'h0000_1234;
        @(posedge pclk); #1;
        penable = 1'b1;
        hits = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge pclk);
            if (apb_c.pready) hits++;
            @(posedge pclk); #1;
        end
        penable = 1'b0;
        @(negedge pclk);
        if (apb_c.pready) hits++;
        @(posedge pclk); #1;
        psel = 3'd0;
        repeat (3) @(posedge pclk);
        #1;
        chk("abort_c_pready_count", hits, 0);
        chk("abort_c_reg3", reg_q_c[127:96], 32'h0);
        chk("abort_c_errcnt", reg_q_c[63:32], 32'h0000_0002);
        xfer(3'd3, 1'b1, 32'h0000_100C, 32'h0000_1234, rd, er, lat);
        chk("retry_c_latency", lat, 6);
        chk("retry_c_pslverr", {31'h0, er}, 32'h0);
        chk("retry_c_reg3", reg_q_c[127:96], 32'h0000_1234);
        bus_idle();
        @(posedge pclk); #1;

        // Asynchronous reset in the middle of A's ACCESS cycle
        psel = 3'd1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h8;
        @(posedge pclk); #1;
        penable = 1'b1;
        #1;
        chk("prerst_a_pready", {31'h0, apb_a.pready}, 32'h1);
        chk("prerst_a_prdata", apb_a.prdata, 32'hDEAD_BEEF);
        preset = 1'b1;
        #1;
        chk("arst_a_pready", {31'h0, apb_a.pready}, 32'h0);
        chk("arst_a_prdata", apb_a.prdata, 32'h0);
        chk("arst_a_reg1", reg_q_a[63:32], 32'h0);
        for (int n = 2; n < 16; n++) begin
            chk($sformatf("arst_a_reg%0d", n), reg_q_a[n*32 +: 32], 32'h0);
        end
        chk("arst_b_reg4", reg_q_b[159:128], 32'h0);
        chk("arst_c_reg3", reg_q_c[127:96], 32'h0);
        bus_idle();
        @(posedge pclk); #1;
        preset = 1'b0;
        @(posedge pclk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
